// File: rtl/matmul_pkg.sv
// matmul_pkg: shared constants, controller state type and latency helper for the matmul block
package matmul_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int MAX_DIM    = 4;
    localparam int DIM_W      = $clog2(MAX_DIM);
    localparam int CNT_W      = $clog2(3 * MAX_DIM);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, WRITE, DONE} ctrl_state_t;

    // pe_valid window length Nk+Nn+Nm-2, expressed on the minus-one encoded fields
    function automatic logic [CNT_W-1:0] latency(input logic [DIM_W-1:0] n, input logic [DIM_W-1:0] k,
                                                 input logic [DIM_W-1:0] m);
        return CNT_W'(n) + CNT_W'(k) + CNT_W'(m) + CNT_W'(1);
    endfunction

endpackage

// File: rtl/matmul_ctrl_cnt.sv
// matmul_ctrl_cnt: loadable saturating down-counter with a zero flag
module matmul_ctrl_cnt
    import matmul_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // load has priority over decrement; decrement holds at zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_q <= cnt_q - CNT_W'(1);
    end

    assign zero_o = cnt_q == '0;

endmodule

// File: rtl/matmul_ctrl.sv
// matmul_ctrl: sequences clear, operand feed, wavefront drain and result write-back for the systolic array
module matmul_ctrl
    import matmul_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [DIM_W-1:0] dim_n_i,
    input  logic [DIM_W-1:0] dim_k_i,
    input  logic [DIM_W-1:0] dim_m_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pe_clear_o,
    output logic             op_rd_en_o,
    output logic [DIM_W-1:0] op_rd_idx_o,
    output logic             pe_valid_o,
    output logic             res_wr_en_o,
    output logic [DIM_W-1:0] res_row_o
);

    ctrl_state_t      state_q, state_d;
    logic [DIM_W-1:0] n_q, k_q, m_q;
    logic             p_zero, v_zero;
    logic             p_load, p_dec, v_load, v_dec;
    logic [CNT_W-1:0] p_val;

    // phase counter times FEED (loaded with K-1) and WRITE (loaded with N-1)
    assign p_load = state_q == CLEAR || (state_q == DRAIN && v_zero);
    assign p_val  = state_q == CLEAR ? CNT_W'(k_q) : CNT_W'(n_q);
    assign p_dec  = state_q == FEED || state_q == WRITE;

    // valid counter runs the pe_valid window, lagging the operand reads by one cycle
    assign v_load = state_q == CLEAR;
    assign v_dec  = state_q == FEED || state_q == DRAIN;

    matmul_ctrl_cnt u_phase_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (p_load),
        .load_val_i (p_val),
        .dec_i      (p_dec),
        .zero_o     (p_zero)
    );

    matmul_ctrl_cnt u_valid_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (v_load),
        .load_val_i (latency(n_q, k_q, m_q)),
        .dec_i      (v_dec),
        .zero_o     (v_zero)
    );

    // next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_i ? CLEAR : IDLE;
            CLEAR:   state_d = FEED;
            FEED:    state_d = p_zero ? DRAIN : FEED;
            DRAIN:   state_d = v_zero ? WRITE : DRAIN;
            WRITE:   state_d = p_zero ? DONE : WRITE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state register and dimension capture on an accepted start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            n_q     <= '0;
            k_q     <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_i) begin
                n_q <= dim_n_i;
                k_q <= dim_k_i;
                m_q <= dim_m_i;
            end
        end
    end

    // outputs registered from the next state so they change cleanly on the clock edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pe_clear_o  <= 1'b0;
            op_rd_en_o  <= 1'b0;
            op_rd_idx_o <= '0;
            pe_valid_o  <= 1'b0;
            res_wr_en_o <= 1'b0;
            res_row_o   <= '0;
        end else begin
            busy_o      <= state_d inside {CLEAR, FEED, DRAIN, WRITE};
            done_o      <= state_d == DONE;
            pe_clear_o  <= state_d == CLEAR;
            op_rd_en_o  <= state_d == FEED;
            op_rd_idx_o <= state_d == FEED && state_q == FEED ? op_rd_idx_o + DIM_W'(1) : '0;
            pe_valid_o  <= (state_q == FEED || state_q == DRAIN) && !v_zero;
            res_wr_en_o <= state_d == WRITE;
            res_row_o   <= state_d == WRITE && state_q == WRITE ? res_row_o + DIM_W'(1) : '0;
        end
    end

endmodule

// File: tb/tb_matmul_ctrl.sv
// tb_matmul_ctrl: directed cycle-by-cycle checks of the matmul controller sequence
module tb_matmul_ctrl;
    import matmul_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             start_i;
    logic [DIM_W-1:0] dim_n_i, dim_k_i, dim_m_i;
    logic             busy_o, done_o, pe_clear_o, op_rd_en_o, pe_valid_o, res_wr_en_o;
    logic [DIM_W-1:0] op_rd_idx_o, res_row_o;
    logic [9:0]       obs;
    int               nvec = 0;
    int               nerr = 0;

    matmul_ctrl dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .dim_n_i     (dim_n_i),
        .dim_k_i     (dim_k_i),
        .dim_m_i     (dim_m_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pe_clear_o  (pe_clear_o),
        .op_rd_en_o  (op_rd_en_o),
        .op_rd_idx_o (op_rd_idx_o),
        .pe_valid_o  (pe_valid_o),
        .res_wr_en_o (res_wr_en_o),
        .res_row_o   (res_row_o)
    );

    always #5 clk_i = ~clk_i;

    assign obs = {busy_o, done_o, pe_clear_o, op_rd_en_o, op_rd_idx_o, pe_valid_o, res_wr_en_o, res_row_o};

    // expected output vector at cycle c of one operation, straight from the cycle table
    function automatic logic [9:0] exp_at(input int c, input int n, input int k, input int m);
        int  nn, nk, nm, l;
        logic busy, done, clr, rd, vld, wr;
        int  idx, row;
        nn   = n + 1;
        nk   = k + 1;
        nm   = m + 1;
        l    = nk + nn + nm - 2;
        busy = c >= 1 && c <= 2 + l + nn;
        done = c == 3 + l + nn;
        clr  = c == 1;
        rd   = c >= 2 && c <= 1 + nk;
        idx  = rd ? c - 2 : 0;
        vld  = c >= 3 && c <= 2 + l;
        wr   = c >= 3 + l && c <= 2 + l + nn;
        row  = wr ? c - 3 - l : 0;
        return {busy, done, clr, rd, 2'(idx), vld, wr, 2'(row)};
    endfunction

    task automatic check(input string tag, input int c, input logic [9:0] e);
        nvec++;
        assert (obs === e) else begin
            nerr++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, e);
        end
    endtask

    // start at cycle 0, optional extra start at cycle s2 (run2 says whether it should be accepted)
    task automatic run(input string tag, input int n, input int k, input int m, input int ncyc,
                       input int s2, input bit run2, input int n2, input int k2, input int m2);
        logic [9:0] e;
        @(posedge clk_i) #1;
        dim_n_i = 2'(n);
        dim_k_i = 2'(k);
        dim_m_i = 2'(m);
        start_i = 1'b1;
        for (int c = 0; c <= ncyc; c++) begin
            @(negedge clk_i);
            e = exp_at(c, n, k, m);
            if (run2 && c >= s2) e = e | exp_at(c - s2, n2, k2, m2);
            check(tag, c, e);
            @(posedge clk_i) #1;
            start_i = c + 1 == s2;
            dim_n_i = c + 1 == s2 ? 2'(n2) : ~2'(n);
            dim_k_i = c + 1 == s2 ? 2'(k2) : ~2'(k);
            dim_m_i = c + 1 == s2 ? 2'(m2) : ~2'(m);
        end
        start_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni  = 1'b0;
        start_i = 1'b0;
        dim_n_i = '0;
        dim_k_i = '0;
        dim_m_i = '0;
        repeat (2) @(posedge clk_i);
        #1 start_i = 1'b1;
        dim_n_i = 2'd3;
        @(negedge clk_i);
        check("reset_start", 0, '0);
        @(posedge clk_i) #1;
        start_i = 1'b0;
        @(negedge clk_i);
        check("reset_hold", 1, '0);
        @(posedge clk_i) #1;
        rst_ni = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            check("reset_release", 0, '0);
        end

        run("full_4x4x4", 3, 3, 3, 19, -1, 1'b0, 0, 0, 0);
        run("min_1x1x1", 0, 0, 0, 8, -1, 1'b0, 0, 0, 0);
        run("rect_2x4x1", 1, 3, 0, 16, 6, 1'b0, 3, 3, 3);
        run("back2back", 0, 0, 0, 13, 6, 1'b1, 0, 0, 0);

        @(posedge clk_i) #1;
        dim_n_i = 2'd3;
        dim_k_i = 2'd3;
        dim_m_i = 2'd3;
        start_i = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk_i);
            check("midrst_run", c, exp_at(c, 3, 3, 3));
            @(posedge clk_i) #1;
            start_i = 1'b0;
        end
        #2 rst_ni = 1'b0;
        #1 check("midrst_async", 7, '0);
        repeat (3) begin
            @(negedge clk_i);
            check("midrst_hold", 7, '0);
        end
        @(posedge clk_i) #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("midrst_release", 0, '0);
        run("after_rst_4x4x4", 3, 3, 3, 19, -1, 1'b0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
